// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- hazard / stall / redirect controller for a 5-stage pipeline
//
// Purpose:
//   Detects register data hazards between the D stage and the E/M stages.
//   Detects structural hazards on the multi-cycle HI/LO unit.
//   Turns both into a stall (freeze PC and F/D, bubble into D/E).
//   A one-cycle RUN/HOLD FSM turns an exception/interrupt request into a
//   single redirect pulse. That pulse overrides any stall.
//   Stall cycles are counted in a saturating 16-bit counter.
//
// Ports:
//   clk                    rising-edge clock
//   reset_n                asynchronous active-low reset
//   d_rs, d_rt             D-stage source register numbers
//   d_tuse_rs, d_tuse_rt   cycles until the operand is consumed (3 = not read)
//   e_dst, m_dst           E/M destination register numbers (0 = none)
//   e_tnew, m_tnew         cycles until the E/M result can be forwarded
//   d_md_op                D instruction uses the HI/LO unit
//   e_md_start             E instruction starts a HI/LO operation
//   e_md_is_div            that operation is a divide (else multiply)
//   int_req                exception/interrupt request from CP0
//   pc_en, d_en            PC and F/D write enable, D-stage register enable
//   e_flush                bubble into the D/E register
//   req_o                  redirect pulse to all stage registers and the PC
//   md_busy                HI/LO unit busy
//   stall_cnt              saturating count of stall cycles

module pipe_ctrl #(
  parameter int MUL_CYC = 5,   // busy cycles for mult/multu (must fit in 4 bits)
  parameter int DIV_CYC = 10   // busy cycles for div/divu (must fit in 4 bits)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic [1:0]  d_tuse_rs,
  input  logic [1:0]  d_tuse_rt,
  input  logic [4:0]  e_dst,
  input  logic [4:0]  m_dst,
  input  logic [1:0]  e_tnew,
  input  logic [1:0]  m_tnew,
  input  logic        d_md_op,
  input  logic        e_md_start,
  input  logic        e_md_is_div,
  input  logic        int_req,
  output logic        pc_en,
  output logic        d_en,
  output logic        e_flush,
  output logic        req_o,
  output logic        md_busy,
  output logic [15:0] stall_cnt
);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  md_cnt_reg, md_cnt_next;
  logic [15:0] stall_cnt_reg, stall_cnt_next;

  logic [4:0]  src_num  [2];
  logic [1:0]  src_tuse [2];
  logic [1:0]  hz_src;
  logic        hz_data;
  logic        hz_md;
  logic        stall;

  assign src_num[0]  = d_rs;
  assign src_num[1]  = d_rt;
  assign src_tuse[0] = d_tuse_rs;
  assign src_tuse[1] = d_tuse_rt;

  // The same hazard rule applies to each source operand.
  // Register $0 never carries a dependency, and tuse==3 means the operand is not read.
  // A hazard exists only if the operand is needed before the producer's result can be forwarded.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign hz_src[gi] = (src_num[gi] != 5'd0) && (src_tuse[gi] != 2'd3) &&
                          (((src_num[gi] == e_dst) && (src_tuse[gi] < e_tnew)) ||
                           ((src_num[gi] == m_dst) && (src_tuse[gi] < m_tnew)));
    end
  endgenerate

  assign hz_data = |hz_src;

  // The HI/LO unit is also unavailable in the cycle its operation starts in E,
  // because md_cnt has not yet been loaded in that cycle.
  assign hz_md = d_md_op && (md_busy || e_md_start);

  // A redirect discards the D instruction, so a stall in that cycle is pointless.
  assign stall   = (hz_data || hz_md) && !req_o;
  assign pc_en   = !stall;
  assign d_en    = !stall;
  assign e_flush = stall;

  assign md_busy   = (md_cnt_reg != 4'd0);
  assign stall_cnt = stall_cnt_reg;

  // Redirect FSM: HOLD blanks int_req for one cycle.
  // This lets CP0 drop its request before it is seen again.
  always_comb begin
    state_next = state_reg;
    req_o      = 1'b0;
    case (state_reg)
      RUN: begin
        req_o = int_req;
        if (int_req) state_next = HOLD;
      end
      HOLD: state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // A start that coincides with a redirect belongs to a squashed instruction.
  // A count that is already running finishes regardless.
  always_comb begin
    md_cnt_next = md_cnt_reg;
    if (e_md_start && !req_o)
      md_cnt_next = e_md_is_div ? 4'(DIV_CYC) : 4'(MUL_CYC);
    else if (md_cnt_reg != 4'd0)
      md_cnt_next = md_cnt_reg - 4'd1;
  end

  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (stall && (stall_cnt_reg != 16'hFFFF))
      stall_cnt_next = stall_cnt_reg + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= RUN;
      md_cnt_reg    <= 4'd0;
      stall_cnt_reg <= 16'd0;
    end else begin
      state_reg     <= state_next;
      md_cnt_reg    <= md_cnt_next;
      stall_cnt_reg <= stall_cnt_next;
    end
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter MUL_CYC, default 5, HI/LO unit busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYC, default 10, HI/LO unit busy cycles for div/divu.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have ports d_rs, d_rt  input  5 each  D-stage source register numbers.
REQ-006 SHALL have ports d_tuse_rs, d_tuse_rt  input  2 each  cycles until operand consumed; 3 = not read.
REQ-007 SHALL have ports e_dst, m_dst  input  5 each  E/M-stage destination register numbers; 0 = none.
REQ-008 SHALL have ports e_tnew, m_tnew  input  2 each  cycles until E/M result forwardable.
REQ-009 SHALL have port d_md_op  input  1  D instruction uses the HI/LO unit (mult/div/mfhi/mflo/mthi/mtlo).
REQ-010 SHALL have ports e_md_start, e_md_is_div  input  1 each  E instruction starts a mult (0) or div (1).
REQ-011 SHALL have port int_req  input  1  exception/interrupt request from CP0.
REQ-012 SHALL have port pc_en  output  1  PC and F/D register write enable.
REQ-013 SHALL have port d_en  output  1  enable input of the D-stage pipeline register.
REQ-014 SHALL have port e_flush  output  1  inserts a bubble into the D/E register.
REQ-015 SHALL have port req_o  output  1  redirect pulse to every stage register and the PC.
REQ-016 SHALL have port md_busy  output  1  HI/LO unit busy.
REQ-017 SHALL have port stall_cnt  output  16  saturating count of stall cycles.

Function
REQ-018 SHALL flag a data hazard on rs when d_rs!=0, d_tuse_rs!=3 and (d_rs==e_dst with d_tuse_rs<e_tnew, or d_rs==m_dst with d_tuse_rs<m_tnew); same rule for rt.
REQ-019 SHALL flag an MD hazard when d_md_op=1 and (md_busy=1 or e_md_start=1).
REQ-020 SHALL compute stall = (data hazard or MD hazard) and not req_o, combinationally in the same cycle.
REQ-021 SHALL drive pc_en = d_en = ~stall and e_flush = stall.
REQ-022 SHALL hold a 4-bit down-counter md_cnt; md_busy = (md_cnt!=0).
REQ-023 SHALL load md_cnt with DIV_CYC if e_md_is_div else MUL_CYC on a cycle with e_md_start=1 and req_o=0; else decrement when nonzero; else hold 0.
REQ-024 SHALL ignore e_md_start on a cycle with req_o=1 (squashed instruction); an already running count SHALL continue to 0.
REQ-025 SHALL implement FSM states RUN and HOLD.
REQ-026 In RUN, SHALL assert req_o = int_req combinationally; on int_req=1 SHALL go to HOLD.
REQ-027 In HOLD, SHALL keep req_o=0, ignore int_req, and return to RUN after exactly one cycle.
REQ-028 SHALL force pc_en=1, d_en=1, e_flush=0 whenever req_o=1 (redirect overrides stall).
REQ-029 SHALL increment stall_cnt by 1 on each cycle with stall=1, saturating at 0xFFFF.
REQ-030 Simultaneous int_req and stall: SHALL assert req_o, SHALL NOT count the stall cycle.

Reset
REQ-031 On reset_n=0, SHALL immediately set state=RUN, md_cnt=0, stall_cnt=0, independent of clk.
REQ-032 During reset, outputs SHALL read pc_en=1, d_en=1, e_flush=0, md_busy=0, and req_o = int_req.
REQ-033 Reset release mid MD operation SHALL leave md_busy=0 from the first post-reset cycle.

Verification
REQ-034 Load-use: e_dst=8, e_tnew=2, d_rs=8, d_tuse_rs=1 -> pc_en=0, d_en=0, e_flush=1 for that cycle, stall_cnt=1 after the edge.
REQ-035 $0 exemption: e_dst=0, e_tnew=2, d_rs=0, d_tuse_rs=0 -> no stall, stall_cnt unchanged.
REQ-036 Divide: e_md_start=1, e_md_is_div=1 for one cycle, then d_md_op=1 held -> md_busy high 10 cycles; stall asserted for 11 cycles (start cycle plus 10 busy cycles), then released.
REQ-037 Interrupt over stall: hazard from REQ-034 plus int_req=1 for 2 cycles -> req_o=1 only in cycle 1, pc_en=1 in cycle 1, stall resumes in cycle 2 (HOLD), FSM back in RUN in cycle 3.
REQ-038 Squash: e_md_start=1 with int_req=1 in the same RUN cycle -> md_busy remains 0.
REQ-039 Async reset: assert reset_n=0 between edges while md_cnt=6 and stall_cnt=37 -> md_busy=0 and stall_cnt=0 before the next edge.
